panel_ctrl: RTL



---
 rtl/panel_pkg.sv | 33 +++
 rtl/panel_evt_arb.sv | 51 +++++
 rtl/panel_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel configuration controller.
// Optional macro FREQ_ACCEL_EN adds the default acceleration window constant.
package panel_pkg;

  localparam int unsigned C_NUM_WAVE     = 4;
  localparam int unsigned C_NUM_FREQ     = 10;
  localparam int unsigned C_DEF_FREQ_IDX = 3;
  localparam int unsigned C_AMP_W        = 3;
  localparam int unsigned C_DEF_AMP      = 7;
  localparam int unsigned C_FTW_W        = 32;
`ifdef FREQ_ACCEL_EN
  localparam int unsigned C_ACCEL_WIN    = 24_000_000;
`endif

  localparam int unsigned C_LUT_IW = $clog2(C_NUM_FREQ);

  typedef enum logic [1:0] {INIT, IDLE, APPLY, WAIT} state_e;
  typedef enum logic [1:0] {EV_WAVE, EV_UP, EV_DOWN, EV_AMP} evt_e;

  // Tuning words for a 50 MHz system clock: 1, 10, 100 Hz, 1, 5, 10, 50, 100, 500 kHz, 1 MHz
  localparam logic [31:0] FTW_PRESET [C_NUM_FREQ] = '{
    32'd86,      32'd859,     32'd8590,     32'd85899,    32'd429497,
    32'd858993,  32'd4294967, 32'd8589935,  32'd42949673, 32'd85899346
  };

  function automatic logic [31:0] ftw_of(input logic [31:0] idx);
    if (idx < 32'(C_NUM_FREQ)) begin
      return FTW_PRESET[idx[C_LUT_IW-1:0]];
    end
    return '0;
  endfunction

endpackage

// File: rtl/panel_evt_arb.sv
// Button pending latch with up/down cancellation and fixed-priority event
// selection (wave > up > down > amp).
module panel_evt_arb
  import panel_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_wave,
  input  logic i_btn_up,
  input  logic i_btn_down,
  input  logic i_btn_amp,
  input  logic i_clr,
  output evt_e o_evt,
  output logic o_evt_valid
);

  logic [3:0] r_pend;
  logic [3:0] w_eff;
  logic [3:0] w_sel;
  logic [3:0] w_clr_mask;
  logic       w_cancel;

  // Opposing frequency requests annihilate and are never offered as events
  assign w_cancel   = r_pend[1] & r_pend[2];
  assign w_eff      = r_pend & ~{1'b0, w_cancel, w_cancel, 1'b0};
  assign w_clr_mask = (i_clr ? w_sel : 4'b0000) | {1'b0, w_cancel, w_cancel, 1'b0};

  always_comb begin
    w_sel       = '0;
    o_evt       = EV_WAVE;
    o_evt_valid = 1'b0;
    if (w_eff[0]) begin
      w_sel[0] = 1'b1; o_evt = EV_WAVE; o_evt_valid = 1'b1;
    end else if (w_eff[1]) begin
      w_sel[1] = 1'b1; o_evt = EV_UP;   o_evt_valid = 1'b1;
    end else if (w_eff[2]) begin
      w_sel[2] = 1'b1; o_evt = EV_DOWN; o_evt_valid = 1'b1;
    end else if (w_eff[3]) begin
      w_sel[3] = 1'b1; o_evt = EV_AMP;  o_evt_valid = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | {i_btn_amp, i_btn_down, i_btn_up, i_btn_wave}) & ~w_clr_mask;
    end
  end

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel configuration controller: serves button events and pushes each
// setting change to the DDS core over Cfg_valid/Cfg_ready. Macro: FREQ_ACCEL_EN.
module panel_ctrl
  import panel_pkg::*;
#(
  parameter int unsigned NUM_WAVE     = C_NUM_WAVE,
  parameter int unsigned NUM_FREQ     = C_NUM_FREQ,
  parameter int unsigned DEF_FREQ_IDX = C_DEF_FREQ_IDX,
  parameter int unsigned AMP_W        = C_AMP_W,
  parameter int unsigned DEF_AMP      = C_DEF_AMP,
  parameter int unsigned FTW_W        = C_FTW_W
`ifdef FREQ_ACCEL_EN
  , parameter int unsigned ACCEL_WIN  = C_ACCEL_WIN
`endif
)(
  input  logic             Fg_clk,
  input  logic             Resetn,
  input  logic             Btn_wave,
  input  logic             Btn_up,
  input  logic             Btn_down,
  input  logic             Btn_amp,
  input  logic             Cfg_ready,
  output logic             Cfg_valid,
  output logic [1:0]       Wave_sel,
  output logic [FTW_W-1:0] Ftw,
  output logic [AMP_W-1:0] Amp_sel,
  output logic             Busy
);

  localparam int unsigned      IDX_W    = (NUM_FREQ > 1) ? $clog2(NUM_FREQ) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_FREQ - 1);
  localparam logic [IDX_W-1:0] IDX_DEF  = IDX_W'(DEF_FREQ_IDX);
  localparam logic [1:0]       WAVE_MAX = 2'(NUM_WAVE - 1);

  state_e           r_state, w_state_n;
  evt_e             r_evt, w_evt_n;
  logic             r_cfg_valid, w_cfg_valid_n;
  logic [1:0]       r_wave, w_wave_n;
  logic [IDX_W-1:0] r_idx, w_idx_n;
  logic [FTW_W-1:0] r_ftw, w_ftw_n;
  logic [AMP_W-1:0] r_amp, w_amp_n;

  evt_e             w_arb_evt;
  logic             w_arb_valid;
  logic             w_clr;
  logic             w_chg;
  logic [1:0]       w_step;
  logic [IDX_W:0]   w_up_sum;
  logic [IDX_W-1:0] w_idx_up;
  logic [IDX_W-1:0] w_idx_dn;

  panel_evt_arb u_arb (
    .i_clk       (Fg_clk),
    .i_rst_n     (Resetn),
    .i_btn_wave  (Btn_wave),
    .i_btn_up    (Btn_up),
    .i_btn_down  (Btn_down),
    .i_btn_amp   (Btn_amp),
    .i_clr       (w_clr),
    .o_evt       (w_arb_evt),
    .o_evt_valid (w_arb_valid)
  );

`ifdef FREQ_ACCEL_EN
  localparam int unsigned GAP_W = $clog2(ACCEL_WIN + 1);

  logic [GAP_W-1:0] r_gap;
  logic [2:0]       r_run;
  logic             r_dir_up;
  logic             w_apply_ud;
  logic             w_same_run;
  logic [2:0]       w_run_n;

  // Run length saturates at 4: every event from the 4th onwards takes the double step
  assign w_apply_ud = (r_state == APPLY) && ((r_evt == EV_UP) || (r_evt == EV_DOWN));
  assign w_same_run = (r_run != 3'd0) && (r_dir_up == (r_evt == EV_UP))
                      && (r_gap < GAP_W'(ACCEL_WIN));
  assign w_run_n    = !w_same_run ? 3'd1 : ((r_run == 3'd4) ? 3'd4 : r_run + 3'd1);
  assign w_step     = (w_run_n >= 3'd4) ? 2'd2 : 2'd1;

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      r_gap    <= '0;
      r_run    <= '0;
      r_dir_up <= 1'b0;
    end else if (w_apply_ud) begin
      r_gap    <= '0;
      r_run    <= w_run_n;
      r_dir_up <= (r_evt == EV_UP);
    end else if (r_gap != GAP_W'(ACCEL_WIN)) begin
      r_gap    <= r_gap + GAP_W'(1);
    end
  end
`else
  assign w_step = 2'd1;
`endif

  assign w_up_sum = {1'b0, r_idx} + (IDX_W + 1)'(w_step);
  assign w_idx_up = (w_up_sum > {1'b0, IDX_MAX}) ? IDX_MAX : w_up_sum[IDX_W-1:0];
  assign w_idx_dn = ({1'b0, r_idx} < (IDX_W + 1)'(w_step)) ? '0 : r_idx - IDX_W'(w_step);

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_evt_n       = r_evt;
    w_cfg_valid_n = r_cfg_valid;
    w_wave_n      = r_wave;
    w_idx_n       = r_idx;
    w_ftw_n       = r_ftw;
    w_amp_n       = r_amp;
    w_clr         = 1'b0;
    w_chg         = 1'b0;
    unique case (r_state)
      // Cfg_valid is registered, so the power-up push rises one cycle after release
      INIT: begin
        if (!r_cfg_valid) begin
          w_cfg_valid_n = 1'b1;
        end else if (Cfg_ready) begin
          w_cfg_valid_n = 1'b0;
          w_state_n     = IDLE;
        end
      end
      IDLE: begin
        if (w_arb_valid) begin
          w_clr     = 1'b1;
          w_evt_n   = w_arb_evt;
          w_state_n = APPLY;
        end
      end
      APPLY: begin
        unique case (r_evt)
          EV_WAVE: begin
            w_wave_n = (r_wave == WAVE_MAX) ? 2'd0 : r_wave + 2'd1;
            w_chg    = (w_wave_n != r_wave);
          end
          EV_UP: begin
            w_idx_n = w_idx_up;
            w_chg   = (w_idx_up != r_idx);
          end
          EV_DOWN: begin
            w_idx_n = w_idx_dn;
            w_chg   = (w_idx_dn != r_idx);
          end
          EV_AMP: begin
            w_amp_n = r_amp + AMP_W'(1);
            w_chg   = (w_amp_n != r_amp);
          end
        endcase
        w_ftw_n = FTW_W'(ftw_of(32'(w_idx_n)));
        if (w_chg) begin
          w_cfg_valid_n = 1'b1;
          w_state_n     = WAIT;
        end else begin
          w_state_n     = IDLE;
        end
      end
      WAIT: begin
        if (Cfg_ready) begin
          w_cfg_valid_n = 1'b0;
          w_state_n     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      r_evt       <= EV_WAVE;
      r_cfg_valid <= 1'b0;
      r_wave      <= '0;
      r_idx       <= IDX_DEF;
      r_ftw       <= FTW_W'(ftw_of(32'(DEF_FREQ_IDX)));
      r_amp       <= AMP_W'(DEF_AMP);
    end else begin
      r_evt       <= w_evt_n;
      r_cfg_valid <= w_cfg_valid_n;
      r_wave      <= w_wave_n;
      r_idx       <= w_idx_n;
      r_ftw       <= w_ftw_n;
      r_amp       <= w_amp_n;
    end
  end

  assign Cfg_valid = r_cfg_valid;
  assign Wave_sel  = r_wave;
  assign Ftw       = r_ftw;
  assign Amp_sel   = r_amp;
  assign Busy      = (r_state != IDLE);

endmodule
